// File: rtl/mure_pkg.sv
// Shared trace-encoder types: retired-uop entry, instruction type and commit row.
//   NrRetiredInstr : lanes per commit row (A..D, A is the MSB lane)
//   uop_entry_s    : one retired uop as delivered by a commit port
//   row_s          : one stored row, lane valids plus uops, MSB lane = A
package mure_pkg;

  localparam int unsigned NrRetiredInstr = 4;
  localparam int unsigned XLen           = 64;

  typedef enum logic [2:0] {
    STD  = 3'h0,
    EXC  = 3'h1,
    INT  = 3'h2,
    ERET = 3'h3,
    UIJ  = 3'h4,
    UJ   = 3'h5,
    NTB  = 3'h6,
    TB   = 3'h7
  } itype_e;

  typedef struct packed {
    itype_e            itype;
    logic [XLen-1:0]   iaddr;
    logic [31:0]       instr;
    logic              compressed;
  } uop_entry_s;

  typedef struct packed {
    logic [NrRetiredInstr-1:0]       ivalids;
    uop_entry_s [NrRetiredInstr-1:0] uop;
  } row_s;

endpackage

// File: rtl/te_ingress_fifo_pkg.sv
// Local constants and helper types for the ingress FIFO.
//   DefaultDepth : default number of stored rows
//   LaneIdxW     : width of a lane index inside a row
//   LaneCntW     : width of a lane count (0..NrRetiredInstr)
//   lane_vec_t   : the four commit lanes as one vector, MSB lane = A
package te_ingress_fifo_pkg;

  import mure_pkg::*;

  localparam int unsigned DefaultDepth = 8;
  localparam int unsigned LaneIdxW     = $clog2(NrRetiredInstr);
  localparam int unsigned LaneCntW     = $clog2(NrRetiredInstr + 1);

  typedef uop_entry_s [NrRetiredInstr-1:0] lane_vec_t;

endpackage

// File: rtl/te_ingress_fifo_if.sv
// Bus between the commit ports, the ingress FIFO and the ingress FSM.
//   commit_*  : commit row in (valid, lane valids, uops A..D) and ready back
//   head_*    : head row presented to the FSM (packed lane valids, uops A..D)
//   pop       : FSM consumed the head row
//   flush     : synchronous clear of all rows
//   empty/full/occupancy/overflow : queue status
// master = commit/FSM side, slave = FIFO.
interface te_ingress_fifo_if
  import mure_pkg::*;
#(
  parameter int unsigned Depth = 8
);

  localparam int unsigned OccW = $clog2(Depth + 1);

  logic                      flush;
  logic                      commit_valid;
  logic [NrRetiredInstr-1:0] commit_ivalids;
  uop_entry_s                commit_uop_a;
  uop_entry_s                commit_uop_b;
  uop_entry_s                commit_uop_c;
  uop_entry_s                commit_uop_d;
  logic                      commit_ready;
  logic [NrRetiredInstr-1:0] head_ivalids;
  uop_entry_s                head_uop_a;
  uop_entry_s                head_uop_b;
  uop_entry_s                head_uop_c;
  uop_entry_s                head_uop_d;
  logic                      pop;
  logic                      empty;
  logic                      full;
  logic [OccW-1:0]           occupancy;
  logic                      overflow;

  modport master (
    output flush, commit_valid, commit_ivalids,
           commit_uop_a, commit_uop_b, commit_uop_c, commit_uop_d, pop,
    input  commit_ready, head_ivalids,
           head_uop_a, head_uop_b, head_uop_c, head_uop_d,
           empty, full, occupancy, overflow
  );

  modport slave (
    input  flush, commit_valid, commit_ivalids,
           commit_uop_a, commit_uop_b, commit_uop_c, commit_uop_d, pop,
    output commit_ready, head_ivalids,
           head_uop_a, head_uop_b, head_uop_c, head_uop_d,
           empty, full, occupancy, overflow
  );

endinterface

// File: rtl/te_ingress_fifo_uop_lane_packer.sv
// Combinational lane compactor: moves valid lanes toward lane A, order kept,
// invalid slots zeroed; resulting ivalids is a thermometer 1..10..0.
//   ivalids : lane valids, MSB = A
//   uops    : lane uops, MSB = A
//   row_c   : packed row
module te_ingress_fifo_uop_lane_packer
  import mure_pkg::*;
  import te_ingress_fifo_pkg::*;
(
  input  logic [NrRetiredInstr-1:0] ivalids,
  input  lane_vec_t                 uops,
  output row_s                      row_c
);

  // Next free slot counted down from one above lane A.
  logic [LaneCntW-1:0] slot;

  always_comb begin
    row_c = '0;
    slot  = LaneCntW'(NrRetiredInstr);
    for (int i = NrRetiredInstr - 1; i >= 0; i--) begin
      if (ivalids[i]) begin
        slot = slot - LaneCntW'(1);
        row_c.uop[slot[LaneIdxW-1:0]] = uops[i];
      end
    end
    // Every slot at or above the last filled one holds a valid uop.
    for (int i = 0; i < NrRetiredInstr; i++) begin
      row_c.ivalids[i] = (LaneCntW'(i) >= slot);
    end
  end

endmodule

// File: rtl/te_ingress_fifo.sv
// Elastic row buffer between the commit ports and the ingress FSM.
// Captures one packed commit row per cycle and presents the head row until
// the FSM pops it. A push while full without a same-cycle pop is dropped and
// recorded in the sticky overflow flag.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : te_ingress_fifo_if slave (commit row in, head row out, status)
module te_ingress_fifo
  import mure_pkg::*;
  import te_ingress_fifo_pkg::*;
#(
  parameter int unsigned Depth = DefaultDepth
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  te_ingress_fifo_if.slave  bus
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned OccW = $clog2(Depth + 1);

  row_s            mem [Depth];
  row_s            in_row;
  row_s            head_row;
  lane_vec_t       in_uops;
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [OccW-1:0] occ_q;
  logic [OccW-1:0] occ_d;
  logic            empty_q;
  logic            full_q;
  logic            overflow_q;
  logic            push_req;
  logic            push_ok;
  logic            pop_ok;
  logic            drop;

  assign in_uops = {bus.commit_uop_a, bus.commit_uop_b, bus.commit_uop_c, bus.commit_uop_d};

  te_ingress_fifo_uop_lane_packer u_packer (
    .ivalids (bus.commit_ivalids),
    .uops    (in_uops),
    .row_c   (in_row)
  );

  // A row with no valid lanes is not a push at all.
  assign push_req = bus.commit_valid && (|bus.commit_ivalids);
  assign pop_ok   = bus.pop && !empty_q;
  // When full the FIFO is never empty, so a raw pop frees the slot.
  assign push_ok  = push_req && (!full_q || bus.pop);
  assign drop     = push_req && full_q && !bus.pop;

  assign bus.commit_ready = !full_q || bus.pop;

  // Occupancy update; flush wins over any same-cycle push/pop.
  always_comb begin
    occ_d = occ_q;
    if (bus.flush) begin
      occ_d = '0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10:   occ_d = occ_q + OccW'(1);
        2'b01:   occ_d = occ_q - OccW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Control state: pointers, occupancy, status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ_q      <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      empty_q <= (occ_d == '0);
      full_q  <= (occ_d == OccW'(Depth));
      if (bus.flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PtrW'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PtrW'(1);
        if (drop)    overflow_q <= 1'b1;
      end
    end
  end

  // Row storage, data flops carry no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok && !bus.flush) begin
      mem[wr_ptr] <= in_row;
    end
  end

  // Empty FIFO presents an all-zero row so stale or unreset data never leaks.
  assign head_row = empty_q ? '0 : mem[rd_ptr];

  assign bus.head_ivalids = head_row.ivalids;
  assign bus.head_uop_a   = head_row.uop[3];
  assign bus.head_uop_b   = head_row.uop[2];
  assign bus.head_uop_c   = head_row.uop[1];
  assign bus.head_uop_d   = head_row.uop[0];
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.occupancy    = occ_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_te_ingress_fifo.sv
// Self-checking bench for te_ingress_fifo: a queue-level reference model
// predicts status and pushes expected rows into a scoreboard; a monitor pops
// and compares whenever the FSM side consumes a head row.
module tb_te_ingress_fifo;
  import mure_pkg::*;

  localparam int unsigned Depth = 8;

  // Expected row, lane 0 = A.
  typedef struct packed {
    logic [3:0]       iv;
    uop_entry_s [3:0] u;
  } tb_row_t;

  logic clk;
  logic rst_n;

  te_ingress_fifo_if #(.Depth(Depth)) bus ();

  te_ingress_fifo #(.Depth(Depth)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  tb_row_t    sb_q[$];
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;
  logic       exp_empty, exp_full, exp_ovf, exp_ready;
  int         exp_occ;
  uop_entry_s ua, ub, uc, ud;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic uop_entry_s rnd_uop();
    uop_entry_s u;
    u.itype      = itype_e'(3'($urandom_range(0, 7)));
    u.iaddr      = {$urandom(), $urandom()};
    u.instr      = $urandom();
    u.compressed = 1'($urandom_range(0, 1));
    return u;
  endfunction

  // Packing rule: collect valid lanes A..D in order, place them from A down.
  function automatic tb_row_t model_pack(input logic [3:0] iv, input uop_entry_s a, input uop_entry_s b,
                                         input uop_entry_s c, input uop_entry_s d);
    uop_entry_s inp[4];
    uop_entry_s lanes[$];
    tb_row_t    r;
    inp = '{a, b, c, d};
    r   = '0;
    for (int k = 0; k < 4; k++) if (iv[3-k]) lanes.push_back(inp[k]);
    for (int k = 0; k < lanes.size(); k++) begin
      r.u[k]    = lanes[k];
      r.iv[3-k] = 1'b1;
    end
    return r;
  endfunction

  // Reference model: snapshot expected status, then apply this cycle's stimulus.
  always @(negedge clk) begin
    logic pop_ok;
    logic push_req;
    if (!rst_n) begin
      m_cnt = 0;
      m_ovf = 1'b0;
      sb_q.delete();
    end
    exp_empty = (m_cnt == 0);
    exp_full  = (m_cnt == Depth);
    exp_occ   = m_cnt;
    exp_ovf   = m_ovf;
    exp_ready = (m_cnt < Depth) || bus.pop;
    if (rst_n) begin
      if (bus.flush) begin
        m_cnt = 0;
        m_ovf = 1'b0;
        sb_q.delete();
      end else begin
        pop_ok   = bus.pop && (m_cnt > 0);
        push_req = bus.commit_valid && (bus.commit_ivalids != 4'b0);
        if (pop_ok) m_cnt--;
        if (push_req) begin
          if (m_cnt < Depth) begin
            sb_q.push_back(model_pack(bus.commit_ivalids, bus.commit_uop_a, bus.commit_uop_b,
                                      bus.commit_uop_c, bus.commit_uop_d));
            m_cnt++;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: status every cycle, zero row when empty, scoreboard on each pop.
  always begin
    tb_row_t r;
    @(negedge clk);
    #1;
    check("empty",     128'(bus.empty),     128'(exp_empty));
    check("full",      128'(bus.full),      128'(exp_full));
    check("occupancy", 128'(bus.occupancy), 128'(exp_occ));
    check("overflow",  128'(bus.overflow),  128'(exp_ovf));
    check("ready",     128'(bus.commit_ready), 128'(exp_ready));
    if (exp_empty) begin
      check("empty_ivalids", 128'(bus.head_ivalids), 128'(4'b0));
      check("empty_uop_a",   128'(bus.head_uop_a),   128'(0));
      check("empty_uop_d",   128'(bus.head_uop_d),   128'(0));
    end
    if (rst_n && !bus.flush && bus.pop && !bus.empty) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: actual=row popped required=no row at %0t", $time);
      end else begin
        r = sb_q.pop_front();
        check("row_ivalids", 128'(bus.head_ivalids), 128'(r.iv));
        check("row_uop_a",   128'(bus.head_uop_a),   128'(r.u[0]));
        check("row_uop_b",   128'(bus.head_uop_b),   128'(r.u[1]));
        check("row_uop_c",   128'(bus.head_uop_c),   128'(r.u[2]));
        check("row_uop_d",   128'(bus.head_uop_d),   128'(r.u[3]));
      end
    end
  end

  task automatic new_uops();
    ua = rnd_uop();
    ub = rnd_uop();
    uc = rnd_uop();
    ud = rnd_uop();
  endtask

  // One cycle of stimulus; returns 1 time unit after the sampling edge.
  task automatic drive(input logic v, input logic [3:0] iv, input logic p, input logic f);
    bus.commit_valid   = v;
    bus.commit_ivalids = iv;
    bus.commit_uop_a   = ua;
    bus.commit_uop_b   = ub;
    bus.commit_uop_c   = uc;
    bus.commit_uop_d   = ud;
    bus.pop            = p;
    bus.flush          = f;
    @(posedge clk);
    #1;
  endtask

  task automatic push_rand(input logic p);
    new_uops();
    drive(1'b1, 4'($urandom_range(1, 15)), p, 1'b0);
  endtask

  initial begin
    tb_row_t first_row;
    int      occ;
    int      op;
    rst_n = 1'b0;
    ua = '0; ub = '0; uc = '0; ud = '0;
    bus.commit_valid = 1'b0; bus.commit_ivalids = '0; bus.pop = 1'b0; bus.flush = 1'b0;
    bus.commit_uop_a = '0; bus.commit_uop_b = '0; bus.commit_uop_c = '0; bus.commit_uop_d = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, 4'b0, 1'b0, 1'b0);
    drive(1'b0, 4'b0, 1'b0, 1'b0);

    // Full row with known addresses.
    new_uops();
    ua.iaddr = 64'h100; ub.iaddr = 64'h104; uc.iaddr = 64'h108; ud.iaddr = 64'h10C;
    drive(1'b1, 4'b1111, 1'b0, 1'b0);
    check("t2_ivalids", 128'(bus.head_ivalids), 128'(4'b1111));
    check("t2_iaddr_a", 128'(bus.head_uop_a.iaddr), 128'(64'h100));
    check("t2_iaddr_d", 128'(bus.head_uop_d.iaddr), 128'(64'h10C));
    drive(1'b0, 4'b0, 1'b1, 1'b0);
    check("t2_empty", 128'(bus.empty), 128'(1'b1));

    // Sparse row B,D packs to A,B.
    new_uops();
    drive(1'b1, 4'b0101, 1'b0, 1'b0);
    check("t3_ivalids", 128'(bus.head_ivalids), 128'(4'b1100));
    check("t3_uop_a",   128'(bus.head_uop_a),   128'(ub));
    check("t3_uop_b",   128'(bus.head_uop_b),   128'(ud));
    check("t3_uop_c",   128'(bus.head_uop_c),   128'(0));
    check("t3_uop_d",   128'(bus.head_uop_d),   128'(0));
    drive(1'b0, 4'b0, 1'b1, 1'b0);

    // Fill, overflow, flush.
    new_uops();
    first_row = model_pack(4'b1011, ua, ub, uc, ud);
    drive(1'b1, 4'b1011, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) push_rand(1'b0);
    check("t4_full",  128'(bus.full),         128'(1'b1));
    check("t4_ready", 128'(bus.commit_ready), 128'(1'b0));
    push_rand(1'b0);
    check("t4_overflow",  128'(bus.overflow),     128'(1'b1));
    check("t4_head_iv",   128'(bus.head_ivalids), 128'(first_row.iv));
    check("t4_head_uopa", 128'(bus.head_uop_a),   128'(first_row.u[0]));
    drive(1'b0, 4'b0, 1'b0, 1'b1);
    check("t4_flush_occ", 128'(bus.occupancy), 128'(0));
    check("t4_flush_ovf", 128'(bus.overflow),  128'(1'b0));

    // Full with simultaneous push+pop, then drain.
    for (int i = 0; i < 8; i++) push_rand(1'b0);
    push_rand(1'b1);
    check("t5_occ", 128'(bus.occupancy), 128'(8));
    check("t5_ovf", 128'(bus.overflow),  128'(1'b0));
    for (int i = 0; i < 8; i++) drive(1'b0, 4'b0, 1'b1, 1'b0);
    check("t5_drained", 128'(bus.empty), 128'(1'b1));

    // Pointer wrap with occupancy held in 1..3.
    push_rand(1'b0);
    push_rand(1'b0);
    occ = 2;
    for (int i = 0; i < 20; i++) begin
      if (occ <= 1)      op = 0;
      else if (occ >= 3) op = 1;
      else               op = $urandom_range(0, 2);
      case (op)
        0:       begin push_rand(1'b0); occ++; end
        1:       begin drive(1'b0, 4'b0, 1'b1, 1'b0); occ--; end
        default: push_rand(1'b1);
      endcase
    end
    while (occ > 0) begin
      drive(1'b0, 4'b0, 1'b1, 1'b0);
      occ--;
    end

    // Random soak: empty rows, pops while empty, pushes while full, rare flush.
    for (int i = 0; i < 400; i++) begin
      new_uops();
      drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 49) == 0));
    end

    // Asynchronous reset with rows stored.
    drive(1'b0, 4'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) push_rand(1'b0);
    drive(1'b0, 4'b0, 1'b0, 1'b0);
    check("t6_occ3", 128'(bus.occupancy), 128'(3));
    rst_n = 1'b0;
    #1;
    check("t6_rst_empty", 128'(bus.empty),     128'(1'b1));
    check("t6_rst_occ",   128'(bus.occupancy), 128'(0));
    check("t6_rst_iv",    128'(bus.head_ivalids), 128'(4'b0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b0, 4'b0, 1'b1, 1'b0);
    drive(1'b0, 4'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
